// File: rtl/axil_bus_pkg.sv
// Shared constants and types for the AXI-Lite 1-to-N interconnect.
// Both address/response engines use the same four-state machine.
package axil_bus_pkg;

    localparam int unsigned RESP_OKAY   = 0;
    localparam int unsigned RESP_DECERR = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_HOLD  = 2'd3
    } chan_state_e;

    typedef chan_state_e w_state_e;
    typedef chan_state_e r_state_e;

    // A single port still needs a one-bit index register.
    function automatic int unsigned port_idx_width(input int unsigned num_m);
        return (num_m <= 1) ? 1 : $clog2(num_m);
    endfunction

endpackage

// File: rtl/axil_bus_chan.sv
// One address+response engine: capture upstream request, decode region, issue downstream, return response.
// Latency: downstream valid one cycle after last capture; upstream response one cycle after downstream response.
// Backpressure: one outstanding transaction; upstream readies stay low until the response is taken.
module axil_bus_chan
    import axil_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_M       = 2,
    parameter int REGION_BITS = 4,
    parameter int SIDE_WIDTH  = 1,
    parameter bit HAS_SIDE    = 1'b0,
    parameter int PLD_WIDTH   = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_WIDTH-1:0]      s_addr,
    input  logic                       s_addr_vld,
    output logic                       s_addr_rdy,
    input  logic [SIDE_WIDTH-1:0]      s_side_dat,
    input  logic                       s_side_vld,
    output logic                       s_side_rdy,
    output logic [PLD_WIDTH-1:0]       s_rsp_dat,
    output logic                       s_rsp_vld,
    input  logic                       s_rsp_rdy,
    output logic [ADDR_WIDTH-1:0]      m_addr,
    output logic [NUM_M-1:0]           m_addr_vld,
    input  logic [NUM_M-1:0]           m_addr_rdy,
    output logic [SIDE_WIDTH-1:0]      m_side_dat,
    output logic [NUM_M-1:0]           m_side_vld,
    input  logic [NUM_M-1:0]           m_side_rdy,
    input  logic [NUM_M*PLD_WIDTH-1:0] m_rsp_dat,
    input  logic [NUM_M-1:0]           m_rsp_vld,
    output logic [NUM_M-1:0]           m_rsp_rdy
);

    localparam int IW = port_idx_width(NUM_M);
    localparam logic [ADDR_WIDTH:0]  NUM_LIM    = (ADDR_WIDTH+1)'(NUM_M);
    localparam logic [PLD_WIDTH-1:0] PLD_DECERR = PLD_WIDTH'(RESP_DECERR);

    chan_state_e           st;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [SIDE_WIDTH-1:0] side_q;
    logic [IW-1:0]         idx_q;
    logic [PLD_WIDTH-1:0]  rsp_q;
    logic                  addr_held, side_held, addr_rdy_q, side_rdy_q;
    logic                  m_addr_vld_q, m_side_vld_q, m_rsp_rdy_q, s_rsp_vld_q;

    logic                  addr_fire, side_fire, addr_ok, side_ok, hit;
    logic                  addr_done, side_done, sel_rsp_vld;
    logic [ADDR_WIDTH-1:0] addr_now, region;
    logic [NUM_M-1:0]      sel_oh;
    logic [PLD_WIDTH-1:0]  sel_rsp_dat;

    always_comb begin
        addr_fire   = s_addr_vld & addr_rdy_q;
        side_fire   = HAS_SIDE & s_side_vld & side_rdy_q;
        addr_ok     = addr_held | addr_fire;
        side_ok     = !HAS_SIDE | side_held | side_fire;
        // Decode the address that completes the request, held or arriving now.
        addr_now    = addr_held ? addr_q : s_addr;
        region      = addr_now >> REGION_BITS;
        hit         = {1'b0, region} < NUM_LIM;
        sel_oh      = NUM_M'(1) << idx_q;
        addr_done   = !m_addr_vld_q | m_addr_rdy[idx_q];
        side_done   = !m_side_vld_q | m_side_rdy[idx_q];
        sel_rsp_vld = m_rsp_vld[idx_q];
        sel_rsp_dat = m_rsp_dat[int'(idx_q)*PLD_WIDTH +: PLD_WIDTH];
    end

    assign s_addr_rdy = addr_rdy_q;
    assign s_side_rdy = side_rdy_q;
    assign s_rsp_dat  = rsp_q;
    assign s_rsp_vld  = s_rsp_vld_q;
    assign m_addr     = addr_q;
    assign m_side_dat = side_q;
    assign m_addr_vld = m_addr_vld_q ? sel_oh : '0;
    assign m_side_vld = m_side_vld_q ? sel_oh : '0;
    assign m_rsp_rdy  = m_rsp_rdy_q  ? sel_oh : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st           <= ST_IDLE;
            addr_q       <= '0;
            side_q       <= '0;
            idx_q        <= '0;
            rsp_q        <= '0;
            addr_held    <= 1'b0;
            side_held    <= 1'b0;
            addr_rdy_q   <= 1'b0;
            side_rdy_q   <= 1'b0;
            m_addr_vld_q <= 1'b0;
            m_side_vld_q <= 1'b0;
            m_rsp_rdy_q  <= 1'b0;
            s_rsp_vld_q  <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (addr_fire) addr_q <= s_addr;
                    if (side_fire) side_q <= s_side_dat;
                    if (addr_ok && side_ok) begin
                        addr_held  <= 1'b0;
                        side_held  <= 1'b0;
                        addr_rdy_q <= 1'b0;
                        side_rdy_q <= 1'b0;
                        idx_q      <= IW'(region);
                        if (hit) begin
                            st           <= ST_ISSUE;
                            m_addr_vld_q <= 1'b1;
                            m_side_vld_q <= HAS_SIDE;
                        end else begin
                            st          <= ST_HOLD;
                            rsp_q       <= PLD_DECERR;
                            s_rsp_vld_q <= 1'b1;
                        end
                    end else begin
                        addr_held  <= addr_ok;
                        side_held  <= side_held | side_fire;
                        addr_rdy_q <= !addr_ok;
                        side_rdy_q <= HAS_SIDE & !(side_held | side_fire);
                    end
                end
                ST_ISSUE: begin
                    if (m_addr_vld_q && m_addr_rdy[idx_q]) m_addr_vld_q <= 1'b0;
                    if (m_side_vld_q && m_side_rdy[idx_q]) m_side_vld_q <= 1'b0;
                    if (addr_done && side_done) begin
                        st          <= ST_RESP;
                        m_rsp_rdy_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (sel_rsp_vld) begin
                        st          <= ST_HOLD;
                        rsp_q       <= sel_rsp_dat;
                        m_rsp_rdy_q <= 1'b0;
                        s_rsp_vld_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (s_rsp_rdy) begin
                        st          <= ST_IDLE;
                        s_rsp_vld_q <= 1'b0;
                        addr_rdy_q  <= 1'b1;
                        side_rdy_q  <= HAS_SIDE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axil_bus_nport.sv
// AXI-Lite 1-to-N interconnect: independent read and write engines routed by fixed address regions.
// Latency: downstream valid one cycle after request capture; upstream response one cycle after downstream response.
// Backpressure: one outstanding read and one outstanding write; upstream readies low while busy.
module axil_bus_nport
    import axil_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int RESP_WIDTH  = 3,
    parameter int NUM_M       = 2,
    parameter int REGION_BITS = 4
) (
    input  logic                           axi_aclk,
    input  logic                           axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [RESP_WIDTH-1:0]          s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [RESP_WIDTH-1:0]          s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_M*ADDR_WIDTH-1:0]    m_axi_awaddr,
    output logic [NUM_M-1:0]               m_axi_awvalid,
    input  logic [NUM_M-1:0]               m_axi_awready,
    output logic [NUM_M*DATA_WIDTH-1:0]    m_axi_wdata,
    output logic [NUM_M*DATA_WIDTH/8-1:0]  m_axi_wstrb,
    output logic [NUM_M-1:0]               m_axi_wvalid,
    input  logic [NUM_M-1:0]               m_axi_wready,
    input  logic [NUM_M*RESP_WIDTH-1:0]    m_axi_bresp,
    input  logic [NUM_M-1:0]               m_axi_bvalid,
    output logic [NUM_M-1:0]               m_axi_bready,
    output logic [NUM_M*ADDR_WIDTH-1:0]    m_axi_araddr,
    output logic [NUM_M-1:0]               m_axi_arvalid,
    input  logic [NUM_M-1:0]               m_axi_arready,
    input  logic [NUM_M*DATA_WIDTH-1:0]    m_axi_rdata,
    input  logic [NUM_M*RESP_WIDTH-1:0]    m_axi_rresp,
    input  logic [NUM_M-1:0]               m_axi_rvalid,
    output logic [NUM_M-1:0]               m_axi_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WR_SIDE    = DATA_WIDTH + STRB_WIDTH;
    localparam int RD_PLD     = DATA_WIDTH + RESP_WIDTH;

    logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
    logic [WR_SIDE-1:0]      wr_side;
    logic [RD_PLD-1:0]       rd_rsp;
    logic [NUM_M*RD_PLD-1:0] rd_pld;
    logic                    rd_side_unused, rd_side_rdy_unused;
    logic [NUM_M-1:0]        rd_side_vld_unused;

    axil_bus_chan #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_M       (NUM_M),
        .REGION_BITS (REGION_BITS),
        .SIDE_WIDTH  (WR_SIDE),
        .HAS_SIDE    (1'b1),
        .PLD_WIDTH   (RESP_WIDTH)
    ) u_wr (
        .clk        (axi_aclk),
        .rst_n      (axi_aresetn),
        .s_addr     (s_axi_awaddr),
        .s_addr_vld (s_axi_awvalid),
        .s_addr_rdy (s_axi_awready),
        .s_side_dat ({s_axi_wstrb, s_axi_wdata}),
        .s_side_vld (s_axi_wvalid),
        .s_side_rdy (s_axi_wready),
        .s_rsp_dat  (s_axi_bresp),
        .s_rsp_vld  (s_axi_bvalid),
        .s_rsp_rdy  (s_axi_bready),
        .m_addr     (wr_addr),
        .m_addr_vld (m_axi_awvalid),
        .m_addr_rdy (m_axi_awready),
        .m_side_dat (wr_side),
        .m_side_vld (m_axi_wvalid),
        .m_side_rdy (m_axi_wready),
        .m_rsp_dat  (m_axi_bresp),
        .m_rsp_vld  (m_axi_bvalid),
        .m_rsp_rdy  (m_axi_bready)
    );

    // Read responses carry {rdata, rresp}; a DECERR therefore reads back as zero data.
    axil_bus_chan #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_M       (NUM_M),
        .REGION_BITS (REGION_BITS),
        .SIDE_WIDTH  (1),
        .HAS_SIDE    (1'b0),
        .PLD_WIDTH   (RD_PLD)
    ) u_rd (
        .clk        (axi_aclk),
        .rst_n      (axi_aresetn),
        .s_addr     (s_axi_araddr),
        .s_addr_vld (s_axi_arvalid),
        .s_addr_rdy (s_axi_arready),
        .s_side_dat (1'b0),
        .s_side_vld (1'b0),
        .s_side_rdy (rd_side_rdy_unused),
        .s_rsp_dat  (rd_rsp),
        .s_rsp_vld  (s_axi_rvalid),
        .s_rsp_rdy  (s_axi_rready),
        .m_addr     (rd_addr),
        .m_addr_vld (m_axi_arvalid),
        .m_addr_rdy (m_axi_arready),
        .m_side_dat (rd_side_unused),
        .m_side_vld (rd_side_vld_unused),
        .m_side_rdy ('0),
        .m_rsp_dat  (rd_pld),
        .m_rsp_vld  (m_axi_rvalid),
        .m_rsp_rdy  (m_axi_rready)
    );

    assign s_axi_rdata = rd_rsp[RD_PLD-1:RESP_WIDTH];
    assign s_axi_rresp = rd_rsp[RESP_WIDTH-1:0];

    for (genvar i = 0; i < NUM_M; i++) begin : g_port
        assign m_axi_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH] = wr_addr;
        assign m_axi_wdata[i*DATA_WIDTH +: DATA_WIDTH]  = wr_side[DATA_WIDTH-1:0];
        assign m_axi_wstrb[i*STRB_WIDTH +: STRB_WIDTH]  = wr_side[WR_SIDE-1:DATA_WIDTH];
        assign m_axi_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] = rd_addr;
        assign rd_pld[i*RD_PLD +: RD_PLD] = {m_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH],
                                             m_axi_rresp[i*RESP_WIDTH +: RESP_WIDTH]};
    end

endmodule

// File: tb/tb_axil_bus_nport.sv
// Directed bench for axil_bus_nport with hand-computed expectations.
module tb_axil_bus_nport;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 3;
    localparam int NM = 2;
    localparam int SW = DW / 8;

    logic             clk;
    logic             rst_n;
    logic [AW-1:0]    s_awaddr;
    logic             s_awvalid, s_awready;
    logic [DW-1:0]    s_wdata;
    logic [SW-1:0]    s_wstrb;
    logic             s_wvalid, s_wready;
    logic [RW-1:0]    s_bresp;
    logic             s_bvalid, s_bready;
    logic [AW-1:0]    s_araddr;
    logic             s_arvalid, s_arready;
    logic [DW-1:0]    s_rdata;
    logic [RW-1:0]    s_rresp;
    logic             s_rvalid, s_rready;
    logic [NM*AW-1:0] m_awaddr;
    logic [NM-1:0]    m_awvalid, m_awready;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*SW-1:0] m_wstrb;
    logic [NM-1:0]    m_wvalid, m_wready;
    logic [NM*RW-1:0] m_bresp;
    logic [NM-1:0]    m_bvalid, m_bready;
    logic [NM*AW-1:0] m_araddr;
    logic [NM-1:0]    m_arvalid, m_arready;
    logic [NM*DW-1:0] m_rdata;
    logic [NM*RW-1:0] m_rresp;
    logic [NM-1:0]    m_rvalid, m_rready;

    int total = 0;
    int bad   = 0;

    axil_bus_nport #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .RESP_WIDTH (RW), .NUM_M (NM), .REGION_BITS (4)
    ) dut (
        .axi_aclk      (clk),        .axi_aresetn   (rst_n),
        .s_axi_awaddr  (s_awaddr),   .s_axi_awvalid (s_awvalid), .s_axi_awready (s_awready),
        .s_axi_wdata   (s_wdata),    .s_axi_wstrb   (s_wstrb),
        .s_axi_wvalid  (s_wvalid),   .s_axi_wready  (s_wready),
        .s_axi_bresp   (s_bresp),    .s_axi_bvalid  (s_bvalid),  .s_axi_bready  (s_bready),
        .s_axi_araddr  (s_araddr),   .s_axi_arvalid (s_arvalid), .s_axi_arready (s_arready),
        .s_axi_rdata   (s_rdata),    .s_axi_rresp   (s_rresp),
        .s_axi_rvalid  (s_rvalid),   .s_axi_rready  (s_rready),
        .m_axi_awaddr  (m_awaddr),   .m_axi_awvalid (m_awvalid), .m_axi_awready (m_awready),
        .m_axi_wdata   (m_wdata),    .m_axi_wstrb   (m_wstrb),
        .m_axi_wvalid  (m_wvalid),   .m_axi_wready  (m_wready),
        .m_axi_bresp   (m_bresp),    .m_axi_bvalid  (m_bvalid),  .m_axi_bready  (m_bready),
        .m_axi_araddr  (m_araddr),   .m_axi_arvalid (m_arvalid), .m_axi_arready (m_arready),
        .m_axi_rdata   (m_rdata),    .m_axi_rresp   (m_rresp),
        .m_axi_rvalid  (m_rvalid),   .m_axi_rready  (m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // port < 0 means the address is unmapped and a DECERR is expected.
    task automatic wr_txn(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int w_lead, input int aw_stall,
                          input int port, input logic [RW-1:0] dn_resp, input logic [RW-1:0] exp_resp);
        logic [NM-1:0] oh;
        chk({tag, " awready idle"}, s_awready, 1'b1);
        chk({tag, " wready idle"}, s_wready, 1'b1);
        s_wdata  = data;
        s_wstrb  = strb;
        s_wvalid = 1'b1;
        if (w_lead > 0) begin
            tick;
            s_wvalid = 1'b0;
            chk({tag, " wready drop"}, s_wready, 1'b0);
            chk({tag, " awready waiting"}, s_awready, 1'b1);
            for (int k = 1; k < w_lead; k++) tick;
        end
        s_awaddr  = addr;
        s_awvalid = 1'b1;
        tick;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk({tag, " awready drop"}, s_awready, 1'b0);
        if (port < 0) begin
            chk({tag, " no awvalid"}, m_awvalid, '0);
            chk({tag, " no wvalid"}, m_wvalid, '0);
        end else begin
            oh = NM'(1) << port;
            chk({tag, " awvalid"}, m_awvalid, oh);
            chk({tag, " wvalid"}, m_wvalid, oh);
            chk({tag, " awaddr"}, m_awaddr[port*AW +: AW], addr);
            chk({tag, " wdata"}, m_wdata[port*DW +: DW], data);
            chk({tag, " wstrb"}, m_wstrb[port*SW +: SW], strb);
            m_wready = oh;
            for (int k = 0; k < aw_stall; k++) begin
                chk({tag, " awvalid held"}, m_awvalid, oh);
                tick;
            end
            if (aw_stall > 0) chk({tag, " wvalid dropped alone"}, m_wvalid, '0);
            m_awready = oh;
            tick;
            m_awready = '0;
            m_wready  = '0;
            chk({tag, " awvalid done"}, m_awvalid, '0);
            chk({tag, " bready"}, m_bready, oh);
            m_bvalid = oh;
            m_bresp[port*RW +: RW] = dn_resp;
            tick;
            m_bvalid = '0;
            chk({tag, " bready done"}, m_bready, '0);
        end
        chk({tag, " bvalid"}, s_bvalid, 1'b1);
        chk({tag, " bresp"}, s_bresp, exp_resp);
        s_bready = 1'b1;
        tick;
        s_bready = 1'b0;
        chk({tag, " bvalid clear"}, s_bvalid, 1'b0);
        chk({tag, " awready back"}, s_awready, 1'b1);
    endtask

    task automatic rd_txn(input string tag, input logic [AW-1:0] addr, input int port,
                          input logic [DW-1:0] dn_data, input logic [RW-1:0] dn_resp, input int r_stall,
                          input logic [DW-1:0] exp_data, input logic [RW-1:0] exp_resp);
        logic [NM-1:0] oh;
        chk({tag, " arready idle"}, s_arready, 1'b1);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        tick;
        s_arvalid = 1'b0;
        chk({tag, " arready drop"}, s_arready, 1'b0);
        if (port < 0) begin
            chk({tag, " no arvalid"}, m_arvalid, '0);
        end else begin
            oh = NM'(1) << port;
            chk({tag, " arvalid"}, m_arvalid, oh);
            chk({tag, " araddr"}, m_araddr[port*AW +: AW], addr);
            m_arready = oh;
            tick;
            m_arready = '0;
            chk({tag, " arvalid done"}, m_arvalid, '0);
            chk({tag, " rready"}, m_rready, oh);
            m_rvalid = oh;
            m_rdata[port*DW +: DW] = dn_data;
            m_rresp[port*RW +: RW] = dn_resp;
            tick;
            m_rvalid = '0;
            chk({tag, " rready done"}, m_rready, '0);
        end
        for (int k = 0; k < r_stall; k++) begin
            chk({tag, " rvalid held"}, s_rvalid, 1'b1);
            chk({tag, " rdata stable"}, s_rdata, exp_data);
            tick;
        end
        chk({tag, " rvalid"}, s_rvalid, 1'b1);
        chk({tag, " rdata"}, s_rdata, exp_data);
        chk({tag, " rresp"}, s_rresp, exp_resp);
        s_rready = 1'b1;
        tick;
        s_rready = 1'b0;
        chk({tag, " rvalid clear"}, s_rvalid, 1'b0);
        chk({tag, " arready back"}, s_arready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        m_awready = '0; m_wready = '0; m_bresp = '0; m_bvalid = '0;
        m_arready = '0; m_rdata = '0; m_rresp = '0; m_rvalid = '0;
        tick;
        tick;
        chk("reset s ctl", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 5'b0);
        chk("reset m ctl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, '0);
        chk("reset s pld", {s_bresp, s_rresp, s_rdata}, '0);
        chk("reset m pld", {m_awaddr, m_araddr, m_wstrb}, '0);
        rst_n = 1'b1;
        tick;

        wr_txn("wr m0", 8'h00, 32'd56, 4'hF, 0, 0, 0, 3'd0, 3'd0);
        wr_txn("wr m1 stall", 8'h10, 32'h1234_5678, 4'h3, 0, 3, 1, 3'd0, 3'd0);
        wr_txn("wr m1 slverr", 8'h1C, 32'hCAFE_0001, 4'h8, 0, 0, 1, 3'd2, 3'd2);
        wr_txn("wr decerr", 8'h20, 32'h0BAD_0BAD, 4'hF, 0, 0, -1, 3'd0, 3'd3);
        wr_txn("wr decerr top", 8'hF0, 32'h5555_AAAA, 4'hF, 0, 0, -1, 3'd0, 3'd3);
        rd_txn("rd decerr", 8'h30, -1, 32'h0, 3'd0, 0, 32'h0, 3'd3);
        rd_txn("rd m1 stall", 8'h14, 1, 32'hDEAD_BEEF, 3'd0, 4, 32'hDEAD_BEEF, 3'd0);
        rd_txn("rd m0", 8'h08, 0, 32'hA5A5_0001, 3'd0, 0, 32'hA5A5_0001, 3'd0);

        fork
            wr_txn("wr w-first", 8'h10, 32'h0F0F_F0F0, 4'h5, 3, 0, 1, 3'd0, 3'd0);
            rd_txn("rd concurrent", 8'h14, 1, 32'h1357_9BDF, 3'd0, 0, 32'h1357_9BDF, 3'd0);
        join

        // Reset while the write is still waiting on the downstream handshake.
        s_awaddr = 8'h00; s_wdata = 32'h11; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("rst pre awvalid", m_awvalid, 2'b01);
        rst_n = 1'b0;
        tick;
        chk("rst mid m ctl", {m_awvalid, m_wvalid, m_bready}, '0);
        chk("rst mid s ctl", {s_awready, s_wready, s_bvalid}, 3'b0);
        chk("rst mid pld", {m_awaddr, m_wstrb}, '0);
        rst_n = 1'b1;
        tick;
        wr_txn("wr post rst", 8'h00, 32'h0000_0077, 4'hF, 0, 0, 0, 3'd0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
